// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one instruction at a time over a
// req/ack handshake and resolves the next PC from the control unit's jump/branch outputs.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IMEM_AW  = 14
) (
   input  logic               clock,
   input  logic               reset,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   input  logic               hold,
   output logic [31:0]        Instruction,
   output logic               instr_valid,
   output logic [31:0]        PC,
   output logic [31:0]        link_addr,
   input  logic               Jrn,
   input  logic               Jmp,
   input  logic               Jal,
   input  logic               Branch,
   input  logic               nBranch,
   input  logic               Zero,
   input  logic [31:0]        Read_data_1,
   output logic               misalign
);

   typedef enum logic {S_REQ, S_EXEC} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_link;

   logic [31:0] w_pc4;
   logic [31:0] w_br_off;
   logic        w_taken;
   logic        w_commit;
   logic [31:0] w_next_pc;

   assign w_pc4    = r_pc + 32'd4;
   assign w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_taken  = (Branch & Zero) | (nBranch & ~Zero);
   assign w_commit = (r_state == S_EXEC) & ~hold & ~reset;

   always_comb begin
      w_next_pc = w_pc4;
      if (Jrn)
         w_next_pc = {Read_data_1[31:2], 2'b00};
      else if (Jmp | Jal)
         w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
      else if (w_taken)
         w_next_pc = w_pc4 + w_br_off;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_instr <= '0;
         r_link  <= '0;
      end else begin
         case (r_state)
            S_REQ: begin
               if (imem_ack) begin
                  r_instr <= imem_rdata;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               // acks arriving here belong to no request and are dropped
               if (!hold) begin
                  r_pc    <= w_next_pc;
                  r_state <= S_REQ;
                  if (Jal)
                     r_link <= w_pc4;
               end
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

   // reset is folded in so the outputs drop the instant reset rises
   assign imem_req    = (r_state == S_REQ) & ~reset;
   assign imem_addr   = r_pc[IMEM_AW+1:2];
   assign instr_valid = w_commit;
   assign misalign    = w_commit & Jrn & (Read_data_1[1:0] != 2'b00);
   assign Instruction = r_instr;
   assign PC          = r_pc;
   assign link_addr   = r_link;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit: sequential fetch, variable ack latency,
// branches, jumps, Jr misalign, hold, PC wrap and asynchronous reset.
module tb_ifetch_unit;

   localparam int unsigned AW = 14;

   logic          clock;
   logic          reset;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic          hold;
   logic [31:0]   Instruction;
   logic          instr_valid;
   logic [31:0]   PC;
   logic [31:0]   link_addr;
   logic          Jrn, Jmp, Jal, Branch, nBranch, Zero;
   logic [31:0]   Read_data_1;
   logic          misalign;

   int unsigned total;
   int unsigned fails;

   ifetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .hold(hold), .Instruction(Instruction), .instr_valid(instr_valid), .PC(PC),
      .link_addr(link_addr), .Jrn(Jrn), .Jmp(Jmp), .Jal(Jal), .Branch(Branch),
      .nBranch(nBranch), .Zero(Zero), .Read_data_1(Read_data_1), .misalign(misalign)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_ctl(input logic [5:0] ctl, input logic [31:0] rd1);
      {Jrn, Jmp, Jal, Branch, nBranch, Zero} = ctl;
      Read_data_1 = rd1;
   endtask

   // S_REQ phase: ack on the lat-th cycle; address must stay constant throughout
   task automatic fetch(input logic [31:0] instr, input int lat, input logic [AW-1:0] exp_addr);
      for (int i = 0; i < lat; i++) begin
         @(negedge clock);
         hold       = 1'b0;
         imem_ack   = (i == lat - 1);
         imem_rdata = (i == lat - 1) ? instr : 32'hDEAD_BEEF;
         #1;
         chk("req_high", imem_req, 1);
         chk("req_addr", imem_addr, exp_addr);
         chk("valid_in_req", instr_valid, 0);
      end
   endtask

   // S_EXEC with hold asserted; stray acks are injected to prove they are ignored
   task automatic hold_cycles(input int n, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         hold       = 1'b1;
         imem_ack   = 1'b1;
         imem_rdata = 32'hBAD0_BAD0;
         #1;
         chk("hold_valid", instr_valid, 0);
         chk("hold_req", imem_req, 0);
         chk("hold_pc", PC, exp_pc);
         chk("hold_instr", Instruction, exp_instr);
      end
   endtask

   // ctl = {Jrn, Jmp, Jal, Branch, nBranch, Zero}
   task automatic commit(input logic [5:0] ctl, input logic [31:0] rd1, input logic exp_mis,
                         input logic [31:0] exp_instr, input logic [31:0] exp_pc,
                         input logic [31:0] exp_next, input logic [31:0] exp_link);
      @(negedge clock);
      imem_ack = 1'b0;
      hold     = 1'b0;
      set_ctl(ctl, rd1);
      #1;
      chk("commit_valid", instr_valid, 1);
      chk("commit_req", imem_req, 0);
      chk("commit_instr", Instruction, exp_instr);
      chk("commit_pc", PC, exp_pc);
      chk("commit_misalign", misalign, exp_mis);
      @(posedge clock);
      #1;
      chk("next_pc", PC, exp_next);
      chk("link_addr", link_addr, exp_link);
      chk("post_valid", instr_valid, 0);
      chk("post_misalign", misalign, 0);
      chk("post_req", imem_req, 1);
      set_ctl(6'b0, 32'h0);
   endtask

   initial begin
      total = 0;
      fails = 0;
      reset = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      hold = 1'b0;
      set_ctl(6'b0, 32'h0);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_mis", misalign, 0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_instr", Instruction, 32'h0);
      chk("rst_link", link_addr, 32'h0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // sequential fetch, latency 1
      fetch(32'h2001_0001, 1, 14'd0);
      commit(6'b000000, 32'h0, 1'b0, 32'h2001_0001, 32'h0, 32'h4, 32'h0);
      fetch(32'h2002_0002, 1, 14'd1);
      commit(6'b000000, 32'h0, 1'b0, 32'h2002_0002, 32'h4, 32'h8, 32'h0);

      // latency 3, then hold 4 cycles with stray acks
      fetch(32'h2003_0003, 3, 14'd2);
      hold_cycles(4, 32'h2003_0003, 32'h8);
      commit(6'b000000, 32'h0, 1'b0, 32'h2003_0003, 32'h8, 32'hC, 32'h0);

      // j 0x10
      fetch(32'h0800_0004, 1, 14'd3);
      commit(6'b010000, 32'h0, 1'b0, 32'h0800_0004, 32'hC, 32'h10, 32'h0);

      // beq imm=-1 taken: 0x14 - 4 = 0x10
      fetch(32'h1000_FFFF, 2, 14'd4);
      commit(6'b000101, 32'h0, 1'b0, 32'h1000_FFFF, 32'h10, 32'h10, 32'h0);

      // bne imm=3 taken: 0x14 + 0xC = 0x20
      fetch(32'h1400_0003, 1, 14'd4);
      commit(6'b000010, 32'h0, 1'b0, 32'h1400_0003, 32'h10, 32'h20, 32'h0);

      // jal 0x100, link 0x24
      fetch(32'h0C00_0040, 1, 14'd8);
      commit(6'b001000, 32'h0, 1'b0, 32'h0C00_0040, 32'h20, 32'h100, 32'h24);

      // jr with misaligned target 0x203 -> 0x200
      fetch(32'h0020_0008, 1, 14'h40);
      commit(6'b100000, 32'h0000_0203, 1'b1, 32'h0020_0008, 32'h100, 32'h200, 32'h24);

      // beq not taken (Zero=0) -> 0x204
      fetch(32'h1000_FFFF, 1, 14'h80);
      commit(6'b000100, 32'h0, 1'b0, 32'h1000_FFFF, 32'h200, 32'h204, 32'h24);

      // Jrn beats Jmp and a taken branch
      fetch(32'h0800_0001, 1, 14'h81);
      commit(6'b110101, 32'hFFFF_FFFC, 1'b0, 32'h0800_0001, 32'h204, 32'hFFFF_FFFC, 32'h24);

      // PC wrap from 0xFFFFFFFC after a hold
      fetch(32'h2004_0004, 2, 14'h3FFF);
      hold_cycles(4, 32'h2004_0004, 32'hFFFF_FFFC);
      commit(6'b000000, 32'h0, 1'b0, 32'h2004_0004, 32'hFFFF_FFFC, 32'h0, 32'h24);

      // reset in the middle of S_REQ, with an ack arriving during reset
      @(negedge clock);
      imem_ack = 1'b0;
      #1;
      chk("midreq_req", imem_req, 1);
      reset = 1'b1;
      #1;
      chk("midreq_rst_req", imem_req, 0);
      chk("midreq_rst_link", link_addr, 32'h0);
      chk("midreq_rst_instr", Instruction, 32'h0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      @(posedge clock);
      #1;
      chk("rst_ack_ignored", Instruction, 32'h0);
      @(negedge clock);
      imem_ack = 1'b0;
      reset    = 1'b0;

      fetch(32'h2005_0005, 1, 14'd0);
      commit(6'b000000, 32'h0, 1'b0, 32'h2005_0005, 32'h0, 32'h4, 32'h0);

      // reset in the middle of a hold
      fetch(32'h2006_0006, 1, 14'd1);
      hold_cycles(2, 32'h2006_0006, 32'h4);
      reset = 1'b1;
      #1;
      chk("midhold_valid", instr_valid, 0);
      chk("midhold_req", imem_req, 0);
      chk("midhold_pc", PC, 32'h0);
      chk("midhold_instr", Instruction, 32'h0);
      @(negedge clock);
      imem_ack = 1'b0;
      hold     = 1'b0;
      reset    = 1'b0;

      fetch(32'h2007_0007, 1, 14'd0);
      commit(6'b000000, 32'h0, 1'b0, 32'h2007_0007, 32'h0, 32'h4, 32'h0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed no end expected end");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decode/control unit. Holds the PC and fetches 32-bit instructions from a variable-latency instruction memory using a req/ack handshake. Presents each instruction to decode and control for exactly one commit cycle. Computes the next PC from the control unit's Jrn/Jmp/Jal/Branch/nBranch outputs and the ALU Zero flag, and produces the Jal link address.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset (must be word-aligned)
IMEM_AW, 14, instruction-memory word-address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  IMEM_AW  word address, equal to PC[IMEM_AW+1:2]
imem_ack  in  1  one-cycle pulse: imem_rdata valid this cycle
imem_rdata  in  32  instruction word from memory
hold  in  1  stall the commit (e.g. I/O busy)
Instruction  out  32  registered instruction; decode takes Opcode=[31:26], Function_opcode=[5:0]
instr_valid  out  1  high on the single cycle in which Instruction commits
PC  out  32  byte address of Instruction
link_addr  out  32  registered PC+4 of the last committed Jal
Jrn, Jmp, Jal, Branch, nBranch  in  1 each  from control unit (combinational from Instruction)
Zero  in  1  ALU zero flag for the current instruction
Read_data_1  in  32  rs register value (Jr target)
misalign  out  1  one-cycle pulse: Jr target had bits[1:0] != 0

Behaviour:
- Reset (asynchronous, takes effect immediately and regardless of state): PC=RESET_PC, Instruction=32'h0, link_addr=32'h0, state=S_REQ. imem_req, instr_valid and misalign are low while reset is high. A transaction in flight is abandoned; an ack arriving during reset is ignored.
- FSM states: S_REQ, S_EXEC.
  - S_REQ: imem_req=1 and imem_addr=PC[IMEM_AW+1:2], both held stable until imem_ack. On ack, Instruction<=imem_rdata and the FSM moves to S_EXEC. Minimum fetch latency: ack in the first S_REQ cycle gives instr_valid on the next cycle.
  - S_EXEC: imem_req=0. instr_valid = ~hold.
    - hold=1: stay in S_EXEC; PC, Instruction and link_addr are unchanged.
    - hold=0: commit edge. PC<=next_pc and the FSM returns to S_REQ.
  - imem_ack seen in S_EXEC is ignored.
- next_pc, evaluated at the commit edge. All arithmetic is 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0. Let pc4 = PC+4. Priority, highest first:
  1. Jrn: {Read_data_1[31:2],2'b00}. misalign=1 for that cycle if Read_data_1[1:0] != 0.
  2. Jmp or Jal: {pc4[31:28], Instruction[25:0], 2'b00}.
  3. Taken branch, where taken = (Branch & Zero) | (nBranch & ~Zero): pc4 + (sign_extend(Instruction[15:0]) << 2).
  4. Otherwise: pc4.
- link_addr<=pc4 at a commit edge where Jal=1; otherwise it holds its value.
- misalign is combinational, valid only when instr_valid=1; it never blocks the jump.
- If several control inputs assert together, the priority above resolves it; no error is flagged.
- One instruction is in flight at a time; there is no prefetch.

Test Plan:
- Reset then sequential fetch, ack latency 1: imem_addr=0, 1, 2 on successive S_REQ phases; instr_valid pulses every 2nd cycle; PC = 0x0, 0x4, 0x8.
- Ack latency 3 cycles: imem_req stays high with imem_addr constant for 3 cycles, instr_valid asserts exactly once, the cycle after ack; acks injected during S_EXEC change nothing.
- PC=0x10, beq with imm=16'hFFFF, Branch=1, Zero=1 -> next PC=0x10. Same instruction with Zero=0 -> 0x14. bne with imm=16'h0003, nBranch=1, Zero=0 -> 0x20.
- PC=0x20, Jal with Instruction[25:0]=26'h40 -> PC=0x100, link_addr=0x24. Then Jr with Read_data_1=0x0000_0203 -> PC=0x200 and misalign pulses once.
- hold=1 for 4 cycles in S_EXEC: instr_valid stays low and PC is stable; on release, instr_valid is high for one cycle and PC advances by 4. Also check PC=0xFFFFFFFC sequential commit -> PC=0x0.
- Assert reset mid-S_REQ and mid-hold: outputs clear within the same cycle, PC=RESET_PC; after release the first fetch is from word address 0 (or RESET_PC>>2 when RESET_PC=0x40, giving 0x10).
